// File: rtl/ad5541_cfg_pkg.sv
// Shared constants and parser state encoding for the AD5541 UART configuration stage.
package ad5541_cfg_pkg;

  localparam logic [7:0] PKT_HDR = 8'hA5;
  localparam logic [7:0] ACK_OK  = 8'h5A;
  localparam logic [7:0] ACK_ERR = 8'hE1;
  localparam int         PKT_LEN = 7;

  typedef enum logic [2:0] {HUNT, S1, S2, S3, S4, FLG, CSUM, APPLY} parse_state_e;

  function automatic logic [7:0] pkt_csum(input logic [7:0] s1, input logic [7:0] s2,
                                          input logic [7:0] s3, input logic [7:0] s4,
                                          input logic [7:0] flg);
    return s1 ^ s2 ^ s3 ^ s4 ^ flg;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte_valid / frame_err.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     state_q;
  logic [2:0]    sync_q;   // [1] is the synchronized line, [2] its previous value
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic          byte_valid_q;
  logic          frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      data_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], rx_i};
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          // Edge-triggered so a line stuck low after a bad stop bit is not re-read as a start.
          if (sync_q[2] && !sync_q[1]) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync_q[1] ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q  <= '0;
            data_q <= {sync_q[1], data_q[7:1]};
            bit_q  <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == FULL) begin
            cnt_q        <= '0;
            state_q      <= RX_IDLE;
            byte_valid_q <= sync_q[1];
            frame_err_q  <= !sync_q[1];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ad5541_code_sel_uart_cfg.sv
// UART command parser holding the AD5541 driver code selects, with a restart pulse per accepted packet.
// Define AD5541_CFG_ACK_TX_EN to build the acknowledge UART transmitter on o_uart_tx.
module ad5541_code_sel_uart_cfg
  import ad5541_cfg_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 87,
  parameter int         TIMEOUT_CLKS = 20000,
  parameter int         RST_PULSE    = 16,
  parameter logic [7:0] DEF_SEL1     = 8'd1,
  parameter logic [7:0] DEF_SEL2     = 8'd2,
  parameter logic [7:0] DEF_SEL3     = 8'd3,
  parameter logic [7:0] DEF_SEL4     = 8'd4
) (
  input  logic       clk_10m,
  input  logic       rst_n,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic [7:0] o_code_sel1,
  output logic [7:0] o_code_sel2,
  output logic [7:0] o_code_sel3,
  output logic [7:0] o_code_sel4,
  output logic       o_contious,
  output logic       o_drv_rst_n,
  output logic       o_pkt_ok,
  output logic       o_pkt_err
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam int RW = $clog2(RST_PULSE + 1);

  logic [7:0]   rx_data;
  logic         byte_valid;
  logic         frame_err;
  parse_state_e state_q;
  logic [7:0]   shadow_q [PKT_LEN-2];
  logic [7:0]   sel_q [4];
  logic [TW-1:0] tmo_q;
  logic [RW-1:0] rst_cnt_q;
  logic         cont_q, drv_rst_n_q, pkt_ok_q, pkt_err_q;
  logic         timeout, csum_ok;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk_10m),
    .rst_n        (rst_n),
    .rx_i         (i_uart_rx),
    .data_o       (rx_data),
    .byte_valid_o (byte_valid),
    .frame_err_o  (frame_err)
  );

  assign timeout = (state_q != HUNT) && (tmo_q == TW'(TIMEOUT_CLKS - 1));
  assign csum_ok = (rx_data == pkt_csum(shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3], shadow_q[4]))
                && (shadow_q[0] != 8'd0) && (shadow_q[1] != 8'd0)
                && (shadow_q[2] != 8'd0) && (shadow_q[3] != 8'd0);

  // One shadow per data position S1..FLG; live outputs only move in APPLY.
  for (genvar gi = 0; gi < PKT_LEN - 2; gi++) begin : g_shadow
    always_ff @(posedge clk_10m or negedge rst_n) begin
      if (!rst_n)
        shadow_q[gi] <= '0;
      else if (byte_valid && (int'(state_q) == int'(S1) + gi))
        shadow_q[gi] <= rx_data;
    end
  end

  always_ff @(posedge clk_10m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      tmo_q     <= '0;
      pkt_ok_q  <= 1'b0;
      pkt_err_q <= 1'b0;
      cont_q    <= 1'b0;
      sel_q[0]  <= DEF_SEL1;
      sel_q[1]  <= DEF_SEL2;
      sel_q[2]  <= DEF_SEL3;
      sel_q[3]  <= DEF_SEL4;
    end else begin
      pkt_ok_q  <= 1'b0;
      pkt_err_q <= 1'b0;
      tmo_q     <= (state_q == HUNT || byte_valid) ? '0 : tmo_q + 1'b1;
      if (state_q == APPLY) begin
        for (int i = 0; i < 4; i++) sel_q[i] <= shadow_q[i];
        cont_q   <= shadow_q[4][0];
        pkt_ok_q <= 1'b1;
        state_q  <= HUNT;
      end else if (frame_err || (timeout && !byte_valid)) begin
        state_q   <= HUNT;
        pkt_err_q <= 1'b1;
      end else if (byte_valid) begin
        case (state_q)
          HUNT:    if (rx_data == PKT_HDR) state_q <= S1;
          CSUM: begin
            if (csum_ok) begin
              state_q <= APPLY;
            end else begin
              state_q   <= HUNT;
              pkt_err_q <= 1'b1;
            end
          end
          default: state_q <= parse_state_e'(state_q + 3'd1);
        endcase
      end
    end
  end

  // Reset value of the counter doubles as the start-up pulse after rst_n release.
  always_ff @(posedge clk_10m or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q   <= RW'(RST_PULSE);
      drv_rst_n_q <= 1'b0;
    end else if (state_q == APPLY) begin
      rst_cnt_q   <= RW'(RST_PULSE);
      drv_rst_n_q <= 1'b0;
    end else if (rst_cnt_q != '0) begin
      rst_cnt_q   <= rst_cnt_q - 1'b1;
      drv_rst_n_q <= (rst_cnt_q == RW'(1));
    end
  end

`ifdef AD5541_CFG_ACK_TX_EN
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [9:0]    tx_shift_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bits_q;
  logic          tx_busy_q;

  always_ff @(posedge clk_10m or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b0;
    end else if (!tx_busy_q) begin
      if (pkt_ok_q || pkt_err_q) begin
        tx_shift_q <= {1'b1, (pkt_ok_q ? ACK_OK : ACK_ERR), 1'b0};
        tx_cnt_q   <= '0;
        tx_bits_q  <= '0;
        tx_busy_q  <= 1'b1;
      end
    end else if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
      tx_cnt_q   <= '0;
      tx_shift_q <= {1'b1, tx_shift_q[9:1]};
      tx_bits_q  <= tx_bits_q + 4'd1;
      if (tx_bits_q == 4'd9) tx_busy_q <= 1'b0;
    end else begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  assign o_uart_tx = tx_shift_q[0];
`else
  assign o_uart_tx = 1'b1;
`endif

  assign o_code_sel1 = sel_q[0];
  assign o_code_sel2 = sel_q[1];
  assign o_code_sel3 = sel_q[2];
  assign o_code_sel4 = sel_q[3];
  assign o_contious  = cont_q;
  assign o_drv_rst_n = drv_rst_n_q;
  assign o_pkt_ok    = pkt_ok_q;
  assign o_pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_ad5541_code_sel_uart_cfg.sv
// Scoreboard bench: stimulus pushes expected packet outcomes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ad5541_code_sel_uart_cfg;

  localparam int BIT = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       o_uart_tx, o_contious, o_drv_rst_n, o_pkt_ok, o_pkt_err;
  logic [7:0] o_code_sel1, o_code_sel2, o_code_sel3, o_code_sel4;

  always #50 clk = ~clk;

  ad5541_code_sel_uart_cfg dut (
    .clk_10m     (clk),
    .rst_n       (rst_n),
    .i_uart_rx   (rx),
    .o_uart_tx   (o_uart_tx),
    .o_code_sel1 (o_code_sel1),
    .o_code_sel2 (o_code_sel2),
    .o_code_sel3 (o_code_sel3),
    .o_code_sel4 (o_code_sel4),
    .o_contious  (o_contious),
    .o_drv_rst_n (o_drv_rst_n),
    .o_pkt_ok    (o_pkt_ok),
    .o_pkt_err   (o_pkt_err)
  );

  typedef struct packed {
    logic        ok;
    logic [31:0] sels;   // {sel4, sel3, sel2, sel1}
    logic        cont;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ack_q[$];
  logic [31:0] live_sels = {8'd4, 8'd3, 8'd2, 8'd1};
  logic        live_cont = 1'b0;
  int          checks = 0;
  int          passes = 0;
  int          events = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  // Reference model: a packet is accepted iff the xor of the five payload bytes equals csum
  // and every select is nonzero; accepted packets replace the live selects.
  task automatic send_pkt(input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3,
                          input logic [7:0] s4, input logic [7:0] flg, input logic [7:0] cs);
    exp_t       e;
    logic [7:0] b [7];
    b = '{8'hA5, s1, s2, s3, s4, flg, cs};
    e.ok = ((s1 ^ s2 ^ s3 ^ s4 ^ flg) == cs) && s1 != 0 && s2 != 0 && s3 != 0 && s4 != 0;
    if (e.ok) begin
      live_sels = {s4, s3, s2, s1};
      live_cont = flg[0];
    end
    e.sels = live_sels;
    e.cont = live_cont;
    exp_q.push_back(e);
    $display("pkt %h %h %h %h %h %h %h -> %s", b[0], s1, s2, s3, s4, flg, cs, e.ok ? "ok" : "err");
    for (int i = 0; i < 7; i++) begin
      send_byte(b[i], 1'b1);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
  endtask

  task automatic push_err();
    exp_t e;
    e.ok   = 1'b0;
    e.sels = live_sels;
    e.cont = live_cont;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (o_pkt_ok || o_pkt_err) begin
      events++;
      if (exp_q.size() == 0) begin
        check("unexpected_event", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_ok", o_pkt_ok, e.ok);
        check("event_kind_err", o_pkt_err, !e.ok);
        check("selects", {o_code_sel4, o_code_sel3, o_code_sel2, o_code_sel1}, e.sels);
        check("contious", o_contious, e.cont);
        if (!e.ok) check("drv_high_on_err", o_drv_rst_n, 1'b1);
        ack_q.push_back(e.ok ? 8'h5A : 8'hE1);
`ifndef AD5541_CFG_ACK_TX_EN
        check("tx_idle", o_uart_tx, 1'b1);
`endif
      end
    end
  end

  always begin : pulse_mon
    int n;
    do @(negedge clk); while (!(rst_n && o_pkt_ok));
    n = 0;
    while (!o_drv_rst_n && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drv_pulse_len", n, 16);
  end

  always @(negedge clk) begin : hold_mon
    logic [32:0] cur, prev;
    logic        have_prev;
    cur = {o_contious, o_code_sel4, o_code_sel3, o_code_sel2, o_code_sel1};
    if (rst_n && have_prev && cur != prev && !o_pkt_ok) check("hold_outputs", cur, prev);
    prev = cur;
    have_prev = rst_n;
  end

`ifdef AD5541_CFG_ACK_TX_EN
  always begin : tx_dec
    logic [7:0] v;
    do @(negedge clk); while (o_uart_tx);
    repeat (BIT / 2) @(negedge clk);
    check("ack_start", o_uart_tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      v[i] = o_uart_tx;
    end
    repeat (BIT) @(negedge clk);
    check("ack_stop", o_uart_tx, 1'b1);
    if (ack_q.size() == 0) check("ack_unexpected", 64'd1, 64'd0);
    else check("ack_byte", v, ack_q.pop_front());
  end
`endif

  initial begin
    int n, ev0, mode, k;
    logic [7:0] s [4];
    logic [7:0] f, cs;

    repeat (3) @(negedge clk);
    check("rst_sels", {o_code_sel4, o_code_sel3, o_code_sel2, o_code_sel1}, 32'h04030201);
    check("rst_contious", o_contious, 1'b0);
    check("rst_drv", o_drv_rst_n, 1'b0);
    check("rst_ok_err", {o_pkt_ok, o_pkt_err}, 2'b00);
    check("rst_tx", o_uart_tx, 1'b1);

    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_drv_rst_n && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("startup_pulse_len", n, 16);
    $display("startup pulse low for %0d cycles", n);
    repeat (20) @(negedge clk);

    send_pkt(8'h05, 8'h0A, 8'h14, 8'h1E, 8'h01, 8'h04);
    send_pkt(8'h05, 8'h0A, 8'h14, 8'h1E, 8'h01, 8'h05);
    send_pkt(8'h05, 8'h00, 8'h14, 8'h1E, 8'h01, 8'h0E);

    push_err();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    ev0 = events;
    n = 0;
    while (events == ev0 && n < 21000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err_seen", events, ev0 + 1);
    check("timeout_latency", (n >= 19900 && n <= 20050), 1'b1);
    $display("timeout err after %0d cycles", n);
    repeat (30) @(negedge clk);
    send_pkt(8'h11, 8'hA5, 8'h33, 8'h44, 8'hFE, 8'h11 ^ 8'hA5 ^ 8'h33 ^ 8'h44 ^ 8'hFE);

    push_err();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h3C, 1'b0);
    $display("frame error byte sent");
    repeat (50) @(negedge clk);
    send_pkt(8'h21, 8'h42, 8'h63, 8'h84, 8'h01, 8'h21 ^ 8'h42 ^ 8'h63 ^ 8'h84 ^ 8'h01);

    ev0 = events;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_event", events, ev0);
    $display("glitch sent, events %0d", events);

    for (int p = 0; p < 3; p++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) s[i] = 8'($urandom_range(1, 255));
      f  = 8'($urandom_range(0, 255));
      if (mode == 2) s[$urandom_range(0, 3)] = 8'h00;
      cs = s[0] ^ s[1] ^ s[2] ^ s[3] ^ f;
      if (mode == 1) begin
        k = $urandom_range(0, 7);
        cs = cs ^ (8'h01 << k);
      end
      if (mode == 3) begin
        send_byte(8'h3C ^ 8'($urandom_range(0, 3)), 1'b1);
        repeat (10) @(negedge clk);
      end
      send_pkt(s[0], s[1], s[2], s[3], f, cs);
    end

    n = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0) && n < 3000) begin
`ifndef AD5541_CFG_ACK_TX_EN
      if (exp_q.size() == 0) ack_q.delete();
`endif
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ad5541_code_sel_uart_cfg.md
Name: ad5541_code_sel_uart_cfg

Overview:
- Upstream configuration stage for the AD5541 gold-code PSK frame driver.
- Receives a framed command from the host over UART, validates it, and holds the four code-segment selects and the continuous-send flag that feed the driver's i_code_sel1..4 / i_contious inputs.
- On every accepted command, issues an active-low restart pulse into the driver's reset, so a new frame starts cleanly with the new selection.

Parameters:
- CLKS_PER_BIT, 87: clk_10m cycles per UART bit (115200 baud at 10 MHz).
- TIMEOUT_CLKS, 20000: maximum idle gap between bytes inside a packet (2 ms).
- RST_PULSE, 16: length in cycles of the o_drv_rst_n low pulse.
- DEF_SEL1 / DEF_SEL2 / DEF_SEL3 / DEF_SEL4, 1 / 2 / 3 / 4: reset values of the selects.

Ports:
- clk_10m, input, 1: system clock, 10 MHz.
- rst_n, input, 1: reset.
- i_uart_rx, input, 1: asynchronous UART RX line; idles high.
- o_uart_tx, output, 1: UART TX line (acknowledge path).
- o_code_sel1 / o_code_sel2 / o_code_sel3 / o_code_sel4, output, 8 each: gold-code row selects, valid range 1..255.
- o_contious, output, 1: continuous frame-send flag.
- o_drv_rst_n, output, 1: restart for the downstream driver, active low.
- o_pkt_ok, output, 1: one-cycle pulse when a packet is accepted.
- o_pkt_err, output, 1: one-cycle pulse on any packet or framing error.

Behaviour:
- Clocking and reset: one clock, clk_10m. rst_n is asynchronous, active low, and applies to all flops.
- Reset values:
  - o_code_selN = DEF_SELN.
  - o_contious = 0.
  - o_drv_rst_n = 0.
  - o_pkt_ok = o_pkt_err = 0.
  - o_uart_tx = 1.
  - RX synchronizer = 1.
  - Parser state = HUNT.
- Start-up pulse: after rst_n deasserts, o_drv_rst_n stays low for RST_PULSE cycles, then goes high.
- UART RX, 8N1, LSB first:
  - i_uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter. The start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the edge is a glitch and RX returns to idle with no error.
  - Each data bit is sampled at its mid-point. The stop bit is sampled at mid-bit and must be 1.
  - A stop bit of 0 is a framing error: the byte is dropped, o_pkt_err pulses, and the parser goes to HUNT.
  - Each good byte produces a one-cycle byte_valid internally.
- Packet format, 7 bytes: 0xA5, sel1, sel2, sel3, sel4, flags, csum.
  - flags bit 0 is contious; bits 7:1 are ignored.
  - csum = sel1 ^ sel2 ^ sel3 ^ sel4 ^ flags.
- Parser states: HUNT → S1 → S2 → S3 → S4 → FLG → CSUM → APPLY → HUNT.
  - HUNT: discards every byte except 0xA5.
  - S1..FLG: shadow-register the received byte.
  - 0xA5 seen in a data position is treated as data; there is no mid-packet resync.
  - CSUM: on csum mismatch, or any shadow select == 0, pulse o_pkt_err and go to HUNT. Live outputs are unchanged.
  - APPLY, lasting one cycle: copy the shadows to o_code_selN and o_contious, pulse o_pkt_ok, load the restart counter with RST_PULSE, and drive o_drv_rst_n low.
  - Latency: outputs update 2 cycles after the csum stop-bit sample.
- Inter-byte timeout:
  - The timeout counter runs in every state except HUNT and clears on each byte_valid.
  - When it reaches TIMEOUT_CLKS-1, the parser goes to HUNT and o_pkt_err pulses. The partial shadows are discarded.
- Restart pulse:
  - o_drv_rst_n stays low while the restart counter is nonzero.
  - A new APPLY during an active pulse reloads the counter, extending the pulse. The outputs take the newest values.
- Output hold: o_code_selN and o_contious change only in APPLY. They are otherwise static, including during the restart pulse, so the driver samples stable values when it leaves reset.
- Simultaneous events: a framing error and a timeout in the same cycle produce a single o_pkt_err pulse.
- Reset mid-packet or mid-pulse: all state returns to reset values immediately, and the start-up pulse is re-run.

Optional Feature:
- Macro: AD5541_CFG_ACK_TX_EN.
- When defined:
  - An 8N1 UART TX at CLKS_PER_BIT sends 0x5A after each o_pkt_ok and 0xE1 after each o_pkt_err.
  - If TX is busy, a new request is dropped. The busy bit is observable internally.
- When undefined: no TX logic is built, and o_uart_tx is tied to 1.

Decomposition:
- Shared package ad5541_cfg_pkg holds:
  - PKT_HDR = 8'hA5, ACK_OK = 8'h5A, ACK_ERR = 8'hE1.
  - PKT_LEN = 7.
  - The parser state encoding.
- Sub-module uart_rx_byte covers the synchronizer, start/data/stop sampling, byte_valid and frame_err. It is reusable by other host links on the board.

Test Plan:
- Reset release with no RX activity → o_drv_rst_n low for exactly 16 cycles, then high; selects read 1/2/3/4 and o_contious = 0.
- Send A5 05 0A 14 1E 01 csum=0x04 → o_pkt_ok pulses once; selects read 5/10/20/30; o_contious = 1; o_drv_rst_n low for 16 cycles starting in the same cycle as o_pkt_ok.
- Same packet with csum 0x05 → o_pkt_err pulses once; outputs keep their previous values; o_drv_rst_n stays high.
- Packet containing sel2 = 0x00 with a correct csum → o_pkt_err; no update.
- Send A5 05 then idle for 20000 cycles → o_pkt_err at the timeout; a following full valid packet is accepted normally.
- Byte sent with stop bit = 0 → o_pkt_err and parser in HUNT. A 20-cycle low glitch on RX → no byte, no error.
- With AD5541_CFG_ACK_TX_EN defined: a valid packet → 0x5A serialized on o_uart_tx, bits 87 cycles wide.
